// File: rtl/cafe_vending_ctrl.sv
// ============================================================================
//  Module      : cafe_vending_ctrl
//  Description : Sequencing controller for the lab 4 coffee machine. Takes a
//                drink selection, latches its price, accumulates coin credit
//                until the price is covered, drives the dispenser for a fixed
//                number of cycles and then issues a one-cycle change pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DISPENSE_CYCLES : cycles dispensar stays high (1..255)
//    W               : width of credit, price and change values
//  Ports
//    clk         in   system clock
//    rst         in   synchronous active-high reset
//    selValid    in   one-cycle pulse, tipoCafe valid
//    tipoCafe    in   drink code (00 expreso, 01 leche, 10 capuccino, 11 mocaccino)
//    coin1       in   one-cycle pulse, coin worth 1
//    coin2       in   one-cycle pulse, coin worth 2
//    cancel      in   one-cycle pulse, user cancel (refund build only)
//    credito     out  accumulated credit
//    costo       out  latched price of the selected drink
//    busy        out  high whenever not idle
//    dispensar   out  dispenser enable
//    cambioValid out  one-cycle change pulse
//    cambio      out  change amount, valid with cambioValid
//  Build option
//    REFUND_CANCEL_EN : when defined, cancel during COLLECT refunds the full
//                       credit (including a coin in the same cycle) without
//                       dispensing. When undefined, cancel is ignored.
// ============================================================================
`default_nettype none

module cafe_vending_ctrl #(
  parameter int DISPENSE_CYCLES = 4,
  parameter int W               = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         selValid,
  input  logic [1:0]   tipoCafe,
  input  logic         coin1,
  input  logic         coin2,
  input  logic         cancel,
  output logic [W-1:0] credito,
  output logic [W-1:0] costo,
  output logic         busy,
  output logic         dispensar,
  output logic         cambioValid,
  output logic [W-1:0] cambio
);

  localparam int         SW         = W + 2;
  localparam logic [W-1:0] CREDIT_MAX = '1;
  localparam logic [7:0] DISP_LOAD  = 8'(DISPENSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t         state;
  logic [7:0]     disp_cnt;
  logic [SW-1:0]  credit_sum;
  logic [W-1:0]   credit_next;

  function automatic logic [W-1:0] price(input logic [1:0] t);
    case (t)
      2'b00:   price = W'(3);
      2'b01:   price = W'(6);
      2'b10:   price = W'(5);
      default: price = W'(7);
    endcase
  endfunction

  // Credit after this cycle's coins; extra headroom bits let the sum be
  // clamped to the maximum instead of wrapping.
  always_comb begin
    credit_sum  = {2'b00, credito} + SW'(coin1) + SW'({coin2, 1'b0});
    credit_next = credito;
    if (credit_sum > {2'b00, CREDIT_MAX})
      credit_next = CREDIT_MAX;
    else
      credit_next = credit_sum[W-1:0];
  end

`ifndef REFUND_CANCEL_EN
  logic unused_cancel;
  assign unused_cancel = cancel;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      disp_cnt    <= 8'd0;
      credito     <= '0;
      costo       <= '0;
      busy        <= 1'b0;
      dispensar   <= 1'b0;
      cambioValid <= 1'b0;
      cambio      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (selValid) begin
            costo   <= price(tipoCafe);
            credito <= '0;
            busy    <= 1'b1;
            state   <= COLLECT;
          end
        end

        COLLECT: begin
          credito <= credit_next;
`ifdef REFUND_CANCEL_EN
          // Cancel wins over covering the price in the same cycle.
          if (cancel) begin
            cambio      <= credit_next;
            cambioValid <= 1'b1;
            state       <= CHANGE;
          end else
`endif
          if (credit_next >= costo) begin
            dispensar <= 1'b1;
            disp_cnt  <= DISP_LOAD;
            state     <= DISPENSE;
          end
        end

        DISPENSE: begin
          // Counter loaded with N-1 on entry gives exactly N high cycles.
          if (disp_cnt == 8'd0) begin
            dispensar   <= 1'b0;
            cambioValid <= 1'b1;
            cambio      <= credito - costo;
            state       <= CHANGE;
          end else begin
            disp_cnt <= disp_cnt - 8'd1;
          end
        end

        CHANGE: begin
          credito     <= '0;
          cambioValid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cafe_vending_ctrl.sv
`default_nettype none

module tb_cafe_vending_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       selValid = 1'b0;
  logic [1:0] tipoCafe = 2'b00;
  logic       coin1 = 1'b0;
  logic       coin2 = 1'b0;
  logic       cancel = 1'b0;
  logic [5:0] credito;
  logic [5:0] costo;
  logic       busy;
  logic       dispensar;
  logic       cambioValid;
  logic [5:0] cambio;

  int checks = 0;
  int errors = 0;

  cafe_vending_ctrl #(.DISPENSE_CYCLES(4), .W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .selValid   (selValid),
    .tipoCafe   (tipoCafe),
    .coin1      (coin1),
    .coin2      (coin2),
    .cancel     (cancel),
    .credito    (credito),
    .costo      (costo),
    .busy       (busy),
    .dispensar  (dispensar),
    .cambioValid(cambioValid),
    .cambio     (cambio)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle pulse of the given coins, then clear them.
  task automatic coins(input logic c1, input logic c2);
    coin1 = c1;
    coin2 = c2;
    tick();
    coin1 = 1'b0;
    coin2 = 1'b0;
  endtask

  task automatic select(input logic [1:0] t);
    selValid = 1'b1;
    tipoCafe = t;
    tick();
    selValid = 1'b0;
  endtask

  // Called on the first dispense cycle; checks 4 high cycles, optionally
  // pulsing coins/selValid meanwhile, and leaves the DUT in CHANGE.
  task automatic dispense_run(input string tag, input logic [5:0] exp_credit, input logic noise);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_disp"}, dispensar, 1);
      chk({tag, "_novalid"}, cambioValid, 0);
      chk({tag, "_credit"}, credito, exp_credit);
      coin1 = noise;
      coin2 = noise;
      selValid = noise;
      tick();
      coin1 = 1'b0;
      coin2 = 1'b0;
      selValid = 1'b0;
    end
  endtask

  task automatic change_check(input string tag, input logic [5:0] exp_change);
    chk({tag, "_chg_valid"}, cambioValid, 1);
    chk({tag, "_chg_val"}, cambio, exp_change);
    chk({tag, "_chg_disp"}, dispensar, 0);
    chk({tag, "_chg_busy"}, busy, 1);
    tick();
    chk({tag, "_idle_valid"}, cambioValid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_credit"}, credito, 0);
    chk({tag, "_idle_cambio_hold"}, cambio, exp_change);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst_credito", credito, 0);
    chk("rst_costo", costo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_disp", dispensar, 0);
    chk("rst_cvalid", cambioValid, 0);
    chk("rst_cambio", cambio, 0);

    // 1: expreso, price 3, coin2 then coin1, exact payment
    select(2'b00);
    chk("t1_busy", busy, 1);
    chk("t1_costo", costo, 3);
    chk("t1_credit0", credito, 0);
    coins(1'b0, 1'b1);
    chk("t1_credit2", credito, 2);
    chk("t1_nodisp", dispensar, 0);
    coins(1'b1, 1'b0);
    chk("t1_credit3", credito, 3);
    dispense_run("t1", 6'd3, 1'b0);
    change_check("t1", 6'd0);

    // 2: mocaccino, price 7, four coin2 -> 8, change 1
    select(2'b11);
    chk("t2_costo", costo, 7);
    for (int i = 1; i <= 4; i++) begin
      coins(1'b0, 1'b1);
      chk("t2_credit", credito, 32'(2 * i));
      if (i < 4) chk("t2_nodisp", dispensar, 0);
    end
    dispense_run("t2", 6'd8, 1'b0);
    change_check("t2", 6'd1);

    // 3: cafe con leche, price 6, both coins together twice; noise in DISPENSE
    select(2'b01);
    chk("t3_costo", costo, 6);
    coins(1'b1, 1'b1);
    chk("t3_credit3", credito, 3);
    chk("t3_nodisp", dispensar, 0);
    coins(1'b1, 1'b1);
    dispense_run("t3", 6'd6, 1'b1);
    change_check("t3", 6'd0);
    chk("t3_costo_hold", costo, 6);

    // 4: coins and cancel while idle are ignored
    coin1 = 1'b1;
    coin2 = 1'b1;
    cancel = 1'b1;
    tick();
    tick();
    coin1 = 1'b0;
    coin2 = 1'b0;
    cancel = 1'b0;
    chk("t4_idle_credit", credito, 0);
    chk("t4_idle_busy", busy, 0);
    select(2'b10);
    chk("t4_costo", costo, 5);
    select(2'b11);
    chk("t4_costo_latched", costo, 5);
    chk("t4_busy", busy, 1);
    coins(1'b0, 1'b1);
    coins(1'b0, 1'b1);
    chk("t4_credit4", credito, 4);
    coins(1'b0, 1'b1);
    chk("t4_credit6", credito, 6);
    chk("t4_disp1", dispensar, 1);

    // 5: reset during second dispense cycle
    tick();
    chk("t5_disp2", dispensar, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_disp", dispensar, 0);
    chk("t5_credit", credito, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cvalid", cambioValid, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_pulse", cambioValid, 0);
      chk("t5_still_idle", busy, 0);
    end

    // 6: cancel together with the covering-short coin
    select(2'b11);
    coins(1'b0, 1'b1);
    chk("t6_credit2", credito, 2);
    cancel = 1'b1;
    coins(1'b1, 1'b0);
    cancel = 1'b0;
`ifdef REFUND_CANCEL_EN
    chk("t6_disp", dispensar, 0);
    change_check("t6", 6'd3);
    chk("t6_disp_after", dispensar, 0);
`else
    chk("t6_credit3", credito, 3);
    chk("t6_busy", busy, 1);
    chk("t6_cvalid", cambioValid, 0);
    chk("t6_disp", dispensar, 0);
    tick();
    chk("t6_stay_busy", busy, 1);
    chk("t6_stay_credit", credito, 3);
    chk("t6_stay_cvalid", cambioValid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
